// File: rtl/time_keeper.sv
// time_keeper: BCD HH:MM:SS time-of-day counter with hour/minute setting.
// Consumes 1 Hz / 5 Hz tick levels and two debounced buttons, all in the
// clk_in domain, and drives BCD digits plus blink/colon controls for the
// display mux. Optional build macro FORMAT_12H_EN switches hours_bcd to a
// 12-hour presentation and adds a pm output; time is always kept as 24h.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_RUN   | clock runs on 1 Hz edges, btn_inc ignored
// ST_SET_H | seconds frozen, btn_inc (and auto-repeat) bumps hours
// ST_SET_M | seconds frozen, btn_inc (and auto-repeat) bumps minutes
// ST_BAD   | unreachable encoding, recovers to ST_RUN next cycle

module time_keeper #(
    parameter logic [7:0]  INIT_HOURS   = 8'h00,
    parameter logic [7:0]  INIT_MINUTES = 8'h00,
    parameter int unsigned REPEAT_DELAY = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       tick_5hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hours_bcd,
    output logic [7:0] minutes_bcd,
    output logic [7:0] seconds_bcd,
    output logic       blank_hours,
    output logic       blank_minutes,
    output logic       colon,
    output logic [1:0] set_state
`ifdef FORMAT_12H_EN
    ,
    output logic       pm
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic [2:0] REP_DLY = 3'(REPEAT_DELAY);

    state_t     state_q, state_d;
    logic [7:0] hours_q, hours_d;
    logic [7:0] minutes_q, minutes_d;
    logic [7:0] seconds_q, seconds_d;
    logic [2:0] rep_q, rep_d;
    logic       tick_1hz_q, tick_5hz_q, btn_mode_q, btn_inc_q;
    logic       blank_hours_q, blank_minutes_q, colon_q;

    logic       t1_edge, t5_edge, mode_edge, inc_edge;
    logic       rep_fire, inc_pulse;

    // BCD increment of a two-digit field, wrapping to 00 after 'top'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign t1_edge   = tick_1hz & ~tick_1hz_q;
    assign t5_edge   = tick_5hz & ~tick_5hz_q;
    assign mode_edge = btn_mode & ~btn_mode_q;
    assign inc_edge  = btn_inc  & ~btn_inc_q;

    // Delayed copies of the inputs used for rising-edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tick_1hz_q <= 1'b0;
            tick_5hz_q <= 1'b0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
        end else begin
            tick_1hz_q <= tick_1hz;
            tick_5hz_q <= tick_5hz;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
        end
    end

    // Auto-repeat: count 5 Hz edges while btn_inc is held; fire once the hold
    // delay has been reached. A fresh press restarts the hold, mode edge wins.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (mode_edge || inc_edge || !btn_inc) begin
            rep_d = 3'd0;
        end else if (t5_edge) begin
            rep_fire = (rep_q >= REP_DLY);
            if (rep_q != 3'd7)
                rep_d = rep_q + 3'd1;
        end
    end

    // A press and a repeat in the same cycle still count as one step.
    assign inc_pulse = (inc_edge | rep_fire) & ~mode_edge;

    // Next-state and time-field update.
    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        case (state_q)
            ST_RUN: begin
                if (t1_edge) begin
                    seconds_d = bcd_inc(seconds_q, 8'h59);
                    if (seconds_q == 8'h59) begin
                        minutes_d = bcd_inc(minutes_q, 8'h59);
                        if (minutes_q == 8'h59)
                            hours_d = bcd_inc(hours_q, 8'h23);
                    end
                end
                if (mode_edge)
                    state_d = ST_SET_H;
            end
            ST_SET_H: begin
                if (mode_edge)
                    state_d = ST_SET_M;
                else if (inc_pulse)
                    hours_d = bcd_inc(hours_q, 8'h23);
            end
            ST_SET_M: begin
                if (mode_edge) begin
                    state_d   = ST_RUN;
                    seconds_d = 8'h00;
                end else if (inc_pulse) begin
                    minutes_d = bcd_inc(minutes_q, 8'h59);
                end
            end
            ST_BAD: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, time and repeat-counter registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_RUN;
            hours_q   <= INIT_HOURS;
            minutes_q <= INIT_MINUTES;
            seconds_q <= 8'h00;
            rep_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            rep_q     <= rep_d;
        end
    end

    // Registered blink and colon controls, following the current state.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            blank_hours_q   <= 1'b0;
            blank_minutes_q <= 1'b0;
            colon_q         <= 1'b0;
        end else begin
            blank_hours_q   <= (state_q == ST_SET_H) & tick_5hz;
            blank_minutes_q <= (state_q == ST_SET_M) & tick_5hz;
            colon_q         <= ((state_q == ST_SET_H) || (state_q == ST_SET_M)) ? 1'b1 : tick_1hz;
        end
    end

    assign minutes_bcd   = minutes_q;
    assign seconds_bcd   = seconds_q;
    assign blank_hours   = blank_hours_q;
    assign blank_minutes = blank_minutes_q;
    assign colon         = colon_q;
    assign set_state     = state_q;

`ifdef FORMAT_12H_EN
    // 24h BCD hours to 12h presentation: 00 shows as 12, 13..23 as 01..11.
    function automatic logic [7:0] to_12h(input logic [7:0] h24);
        case (h24)
            8'h00:   return 8'h12;
            8'h13:   return 8'h01;
            8'h14:   return 8'h02;
            8'h15:   return 8'h03;
            8'h16:   return 8'h04;
            8'h17:   return 8'h05;
            8'h18:   return 8'h06;
            8'h19:   return 8'h07;
            8'h20:   return 8'h08;
            8'h21:   return 8'h09;
            8'h22:   return 8'h10;
            8'h23:   return 8'h11;
            default: return h24;
        endcase
    endfunction

    assign hours_bcd = to_12h(hours_q);
    assign pm        = (hours_q >= 8'h12);
`else
    assign hours_bcd = hours_q;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: a directed vector table, directed multi-cycle
// sequences, then randomized stimulus, all checked cycle by cycle against a
// seconds-of-day reference model. Honors FORMAT_12H_EN when defined.

module tb_time_keeper;

    localparam logic [7:0] P_INIT_H = 8'h23;
    localparam logic [7:0] P_INIT_M = 8'h59;
    localparam int         P_REP    = 3;

    logic       clk_in = 1'b0;
    logic       r_reset = 1'b1;
    logic       r_t1 = 1'b0, r_t5 = 1'b0, r_md = 1'b0, r_inc = 1'b0;
    logic [7:0] hours_bcd, minutes_bcd, seconds_bcd;
    logic       blank_hours, blank_minutes, colon;
    logic [1:0] set_state;
`ifdef FORMAT_12H_EN
    logic       pm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    time_keeper #(
        .INIT_HOURS   (P_INIT_H),
        .INIT_MINUTES (P_INIT_M),
        .REPEAT_DELAY (P_REP)
    ) dut (
        .clk_in        (clk_in),
        .reset         (r_reset),
        .tick_1hz      (r_t1),
        .tick_5hz      (r_t5),
        .btn_mode      (r_md),
        .btn_inc       (r_inc),
        .hours_bcd     (hours_bcd),
        .minutes_bcd   (minutes_bcd),
        .seconds_bcd   (seconds_bcd),
        .blank_hours   (blank_hours),
        .blank_minutes (blank_minutes),
        .colon         (colon),
        .set_state     (set_state)
`ifdef FORMAT_12H_EN
        ,
        .pm            (pm)
`endif
    );

    always #5 clk_in = ~clk_in;

    // ---------------- helpers ----------------
    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] disp_h(input int h);
`ifdef FORMAT_12H_EN
        if (h == 0)  return 8'h12;
        if (h > 12)  return int2bcd(h - 12);
`endif
        return int2bcd(h);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Time held as plain integers; a running second is one step of
    // seconds-of-day modulo 86400.
    int m_h, m_m, m_s, m_st, m_cnt;
    bit m_bh, m_bm, m_col;
    bit p_t1, p_t5, p_md, p_inc;

    task automatic model_update();
        bit e_t1, e_t5, e_md, e_inc, fire;
        int old, tot;
        if (r_reset) begin
            m_h = bcd2int(P_INIT_H); m_m = bcd2int(P_INIT_M); m_s = 0;
            m_st = 0; m_cnt = 0; m_bh = 0; m_bm = 0; m_col = 0;
            p_t1 = 0; p_t5 = 0; p_md = 0; p_inc = 0;
            return;
        end
        e_t1  = r_t1  && !p_t1;
        e_t5  = r_t5  && !p_t5;
        e_md  = r_md  && !p_md;
        e_inc = r_inc && !p_inc;
        fire  = 0;
        if (e_md || e_inc || !r_inc) m_cnt = 0;
        else if (e_t5) begin
            fire = (m_cnt >= P_REP);
            if (m_cnt < 7) m_cnt++;
        end
        old   = m_st;
        m_bh  = (old == 1) && r_t5;
        m_bm  = (old == 2) && r_t5;
        m_col = (old == 1 || old == 2) ? 1'b1 : r_t1;
        if (old == 0 && e_t1) begin
            tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = tot / 3600; m_m = (tot / 60) % 60; m_s = tot % 60;
        end
        if (e_md) begin
            if (old == 2) m_s = 0;
            m_st = (old + 1) % 3;
        end else if (e_inc || fire) begin
            if (old == 1)      m_h = (m_h + 1) % 24;
            else if (old == 2) m_m = (m_m + 1) % 60;
        end
        p_t1 = r_t1; p_t5 = r_t5; p_md = r_md; p_inc = r_inc;
    endtask

    task automatic check_model();
        chk("mdl_hours",   hours_bcd,           disp_h(m_h));
        chk("mdl_minutes", minutes_bcd,         int2bcd(m_m));
        chk("mdl_seconds", seconds_bcd,         int2bcd(m_s));
        chk("mdl_state",   {6'd0, set_state},   8'(m_st));
        chk("mdl_blank_h", {7'd0, blank_hours}, {7'd0, m_bh});
        chk("mdl_blank_m", {7'd0, blank_minutes}, {7'd0, m_bm});
        chk("mdl_colon",   {7'd0, colon},       {7'd0, m_col});
`ifdef FORMAT_12H_EN
        chk("mdl_pm",      {7'd0, pm},          {7'd0, m_h >= 12});
`endif
    endtask

    task automatic step();
        @(posedge clk_in);
        model_update();
        #1;
        check_model();
    endtask

    task automatic pulse_mode(); r_md  = 1; step(); r_md  = 0; step(); endtask
    task automatic pulse_inc();  r_inc = 1; step(); r_inc = 0; step(); endtask
    task automatic pulse_t1();   r_t1  = 1; step(); r_t1  = 0; step(); endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst, t1, t5, md, inc;
        logic [7:0] h, m, s;
        logic [1:0] st;
        logic       bh, bm, col;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic rst, t1, t5, md, inc,
                        input logic [7:0] h, m, s, input logic [1:0] st,
                        input logic bh, bm, col);
        vec_t v;
        v.rst = rst; v.t1 = t1; v.t5 = t5; v.md = md; v.inc = inc;
        v.h = h; v.m = m; v.s = s; v.st = st; v.bh = bh; v.bm = bm; v.col = col;
        vq.push_back(v);
    endtask

    initial begin
        //   rst t1 t5 md inc   hh     mm     ss   st bh bm col
        addv(1, 0, 0, 0, 0, 8'h23, 8'h59, 8'h00, 0, 0, 0, 0);
        addv(0, 1, 0, 0, 0, 8'h23, 8'h59, 8'h01, 0, 0, 0, 1);
        addv(0, 1, 0, 0, 0, 8'h23, 8'h59, 8'h01, 0, 0, 0, 1);
        addv(0, 0, 0, 0, 0, 8'h23, 8'h59, 8'h01, 0, 0, 0, 0);
        addv(0, 1, 0, 0, 1, 8'h23, 8'h59, 8'h02, 0, 0, 0, 1);
        addv(0, 0, 0, 1, 0, 8'h23, 8'h59, 8'h02, 1, 0, 0, 0);
        addv(0, 0, 1, 1, 1, 8'h00, 8'h59, 8'h02, 1, 1, 0, 1);
        addv(0, 1, 0, 0, 1, 8'h00, 8'h59, 8'h02, 1, 0, 0, 1);
        addv(0, 0, 1, 0, 0, 8'h00, 8'h59, 8'h02, 1, 1, 0, 1);
        addv(0, 0, 1, 1, 0, 8'h00, 8'h59, 8'h02, 2, 1, 0, 1);
        addv(0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h02, 2, 0, 1, 1);
        addv(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02, 2, 0, 0, 1);
        addv(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        addv(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);

        foreach (vq[i]) begin
            r_reset = vq[i].rst; r_t1 = vq[i].t1; r_t5 = vq[i].t5;
            r_md = vq[i].md; r_inc = vq[i].inc;
            step();
            chk("tbl_hours",   hours_bcd,     disp_h(bcd2int(vq[i].h)));
            chk("tbl_minutes", minutes_bcd,   vq[i].m);
            chk("tbl_seconds", seconds_bcd,   vq[i].s);
            chk("tbl_state",   {6'd0, set_state}, {6'd0, vq[i].st});
            chk("tbl_blank_h", {7'd0, blank_hours},   {7'd0, vq[i].bh});
            chk("tbl_blank_m", {7'd0, blank_minutes}, {7'd0, vq[i].bm});
            chk("tbl_colon",   {7'd0, colon},         {7'd0, vq[i].col});
        end
        r_reset = 0; r_t1 = 0; r_t5 = 0; r_md = 0; r_inc = 0;

        // Midnight rollover with one-cycle latency.
        r_reset = 1; step(); r_reset = 0;
        for (int i = 0; i < 58; i++) pulse_t1();
        chk("roll_pre_s", seconds_bcd, 8'h58);
        r_t1 = 1; step();
        chk("roll_59_s", seconds_bcd, 8'h59);
        chk("roll_59_m", minutes_bcd, 8'h59);
        r_t1 = 0; step();
        r_t1 = 1; step();
        chk("roll_00_h", hours_bcd,   disp_h(0));
        chk("roll_00_m", minutes_bcd, 8'h00);
        chk("roll_00_s", seconds_bcd, 8'h00);
        r_t1 = 0; step();

        // Reach 10:20:33, then set hours to 13 and return to RUN.
        pulse_mode();
        for (int i = 0; i < 10; i++) pulse_inc();
        pulse_mode();
        for (int i = 0; i < 20; i++) pulse_inc();
        pulse_mode();
        for (int i = 0; i < 33; i++) pulse_t1();
        chk("t2_start_h", hours_bcd,   disp_h(10));
        chk("t2_start_m", minutes_bcd, 8'h20);
        chk("t2_start_s", seconds_bcd, 8'h33);
        pulse_mode();
        for (int i = 0; i < 3; i++) pulse_inc();
        chk("t2_set_h",  hours_bcd,   disp_h(13));
        chk("t2_set_s",  seconds_bcd, 8'h33);
        chk("t2_set_st", {6'd0, set_state}, 8'd1);
        pulse_mode();
        pulse_mode();
        chk("t2_run_h",  hours_bcd,   disp_h(13));
        chk("t2_run_m",  minutes_bcd, 8'h20);
        chk("t2_run_s",  seconds_bcd, 8'h00);
        chk("t2_run_st", {6'd0, set_state}, 8'd0);

        // Auto-repeat on minutes from 58.
        pulse_mode();
        pulse_mode();
        for (int i = 0; i < 38; i++) pulse_inc();
        chk("rep_pre_m", minutes_bcd, 8'h58);
        r_inc = 1; step();
        chk("rep_press_m", minutes_bcd, 8'h59);
        for (int k = 1; k <= 6; k++) begin
            logic [7:0] exp_m;
            r_t5 = 1; step();
            r_t5 = 0; step();
            exp_m = (k <= 3) ? 8'h59 : int2bcd(k - 4);
            chk("rep_hold_m", minutes_bcd, exp_m);
        end
        r_inc = 0; step();
        r_t5 = 1; step(); r_t5 = 0; step();
        chk("rep_release_m", minutes_bcd, 8'h02);
        pulse_mode();

        // Mode and inc rising together in RUN.
        r_md = 1; r_inc = 1; step();
        chk("sim_st", {6'd0, set_state}, 8'd1);
        chk("sim_h",  hours_bcd, disp_h(13));
        r_md = 0; r_inc = 0; step();

        // Reset while setting minutes with btn_inc held.
        pulse_mode();
        r_inc = 1; step();
        r_t5 = 1; step();
        chk("rst_pre_bm", {7'd0, blank_minutes}, 8'd1);
        r_reset = 1; step();
        chk("rst_h",  hours_bcd,   disp_h(23));
        chk("rst_m",  minutes_bcd, 8'h59);
        chk("rst_s",  seconds_bcd, 8'h00);
        chk("rst_st", {6'd0, set_state}, 8'd0);
        chk("rst_bh", {7'd0, blank_hours},   8'd0);
        chk("rst_bm", {7'd0, blank_minutes}, 8'd0);
        r_reset = 0; step();
        for (int i = 0; i < 8; i++) begin r_t5 = ~r_t5; step(); end
        r_inc = 0; r_t5 = 0; step();
        chk("rst_after_h",  hours_bcd,   disp_h(23));
        chk("rst_after_m",  minutes_bcd, 8'h59);
        chk("rst_after_st", {6'd0, set_state}, 8'd0);

`ifdef FORMAT_12H_EN
        chk("f12_23_h",  hours_bcd, 8'h11);
        chk("f12_23_pm", {7'd0, pm}, 8'd1);
        pulse_mode();
        pulse_inc();
        chk("f12_00_h",  hours_bcd, 8'h12);
        chk("f12_00_pm", {7'd0, pm}, 8'd0);
        for (int i = 0; i < 15; i++) pulse_inc();
        chk("f12_15_h",  hours_bcd, 8'h03);
        chk("f12_15_pm", {7'd0, pm}, 8'd1);
        pulse_mode();
        pulse_mode();
`endif

        // Randomized stimulus against the model.
        r_reset = 1; step(); r_reset = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3, 0) == 0)  r_t1  = ~r_t1;
            if ($urandom_range(2, 0) == 0)  r_t5  = ~r_t5;
            if ($urandom_range(11, 0) == 0) r_md  = ~r_md;
            if ($urandom_range(9, 0) == 0)  r_inc = ~r_inc;
            r_reset = ($urandom_range(399, 0) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
